// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial addition sequencer for an external 1-bit full adder.
// It captures two WIDTH-bit operands and a carry-in, then presents one bit pair per
// clock (LSB first) to the full adder and keeps the running carry in a flip-flop.
// It returns a registered sum/carry-out together with a one-cycle done pulse.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   ena               clock enable; all state freezes while low
//   start             begin an addition (accepted in IDLE or DONE)
//   op_a, op_b, cin   operands and carry-in, captured on the accepted start edge
//   fa_a, fa_b, fa_cin  full adder inputs (0 outside RUN)
//   fa_sum, fa_cout   full adder outputs (combinational from fa_*)
//   busy              high while in RUN
//   done              one-cycle pulse when sum/cout become valid
//   sum, cout         registered result and final carry
module serial_add_ctrl #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_sum,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [WIDTH-1:0]   r_a_sr,   w_a_sr_nxt;
   logic [WIDTH-1:0]   r_b_sr,   w_b_sr_nxt;
   logic [WIDTH-1:0]   r_s_sr,   w_s_sr_nxt;
   logic               r_carry,  w_carry_nxt;
   logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
   logic [WIDTH-1:0]   r_sum,    w_sum_nxt;
   logic               r_cout,   w_cout_nxt;
   logic               r_busy,   w_busy_nxt;
   logic               r_done,   w_done_nxt;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath next values; everything holds unless ena is high
   always_comb begin
      w_state_nxt   = r_state;
      w_a_sr_nxt    = r_a_sr;
      w_b_sr_nxt    = r_b_sr;
      w_s_sr_nxt    = r_s_sr;
      w_carry_nxt   = r_carry;
      w_bit_cnt_nxt = r_bit_cnt;
      w_sum_nxt     = r_sum;
      w_cout_nxt    = r_cout;
      w_busy_nxt    = r_busy;
      w_done_nxt    = r_done;

      if (ena) begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  w_a_sr_nxt    = op_a;
                  w_b_sr_nxt    = op_b;
                  w_carry_nxt   = cin;
                  w_bit_cnt_nxt = '0;
                  w_s_sr_nxt    = '0;
                  w_state_nxt   = S_RUN;
               end else begin
                  w_state_nxt   = S_IDLE;
               end
            end
            S_RUN: begin
               // Sum bits enter at the MSB so the LSB lands in bit 0 after WIDTH shifts
               w_s_sr_nxt    = {fa_sum, r_s_sr[WIDTH-1:1]};
               w_a_sr_nxt    = {1'b0, r_a_sr[WIDTH-1:1]};
               w_b_sr_nxt    = {1'b0, r_b_sr[WIDTH-1:1]};
               w_carry_nxt   = fa_cout;
               w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
               if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
                  w_sum_nxt   = {fa_sum, r_s_sr[WIDTH-1:1]};
                  w_cout_nxt  = fa_cout;
                  w_state_nxt = S_DONE;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
         w_busy_nxt = (w_state_nxt == S_RUN);
         w_done_nxt = (w_state_nxt == S_DONE);
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a_sr    <= '0;
         r_b_sr    <= '0;
         r_s_sr    <= '0;
         r_carry   <= 1'b0;
         r_bit_cnt <= '0;
         r_sum     <= '0;
         r_cout    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_a_sr    <= w_a_sr_nxt;
         r_b_sr    <= w_b_sr_nxt;
         r_s_sr    <= w_s_sr_nxt;
         r_carry   <= w_carry_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_sum     <= w_sum_nxt;
         r_cout    <= w_cout_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
      end
   end

   // Full adder drive is gated by busy so the pins sit at 0 outside RUN
   assign fa_a   = r_busy & r_a_sr[0];
   assign fa_b   = r_busy & r_b_sr[0];
   assign fa_cin = r_busy & r_carry;

   assign busy = r_busy;
   assign done = r_done;
   assign sum  = r_sum;
   assign cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed scenarios plus a random sweep,
// checked against plain-arithmetic expectations and cycle-count timing rules.
module tb_serial_add_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         ena;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         fa_a, fa_b, fa_cin;
   logic         fa_sum, fa_cout;
   logic         busy, done;
   logic [W-1:0] sum;
   logic         cout;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   // Environment: the shared 1-bit full adder cell
   assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .start   (start),
      .op_a    (op_a),
      .op_b    (op_b),
      .cin     (cin),
      .fa_a    (fa_a),
      .fa_b    (fa_b),
      .fa_cin  (fa_cin),
      .fa_sum  (fa_sum),
      .fa_cout (fa_cout),
      .busy    (busy),
      .done    (done),
      .sum     (sum),
      .cout    (cout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Called at a negedge; start is accepted on the next rising edge (E0).
   // Returns at the negedge just after E0 (cycle k=0).
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      op_a  = a;
      op_b  = b;
      cin   = ci;
      start = 1'b1;
      ena   = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Waits for done, sampling at each negedge k after E0.
   // mode 0: ena always 1; mode 1: random ena; mode 2: ena low for sl edges from k=st.
   task automatic wait_done(input int mode, input int st, input int sl,
                            output int cyc, output int stalls, output int busy_cyc);
      logic [2:0] fa_snap;
      fa_snap  = 3'b000;
      cyc      = 0;
      stalls   = 0;
      busy_cyc = 0;
      while (done !== 1'b1 && cyc < 200) begin
         if (busy === 1'b1) busy_cyc++;
         if (mode == 2 && cyc == st) fa_snap = {fa_a, fa_b, fa_cin};
         if (mode == 2 && cyc > st && cyc <= st + sl)
            check("stall_fa_hold", {29'd0, fa_a, fa_b, fa_cin}, {29'd0, fa_snap});
         if (mode == 1)      ena = ($urandom_range(3) != 0);
         else if (mode == 2) ena = !(cyc >= st && cyc < st + sl);
         else                ena = 1'b1;
         if (!ena) stalls++;
         @(negedge clk);
         cyc++;
      end
      ena = 1'b1;
   endtask

   initial begin
      int cyc, stalls, bcyc, c;
      logic [W-1:0] a, b;
      logic         ci;
      logic [W:0]   exp_r;

      rst_n = 1'b0;
      ena   = 1'b0;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      cin   = 1'b0;

      // Reset state
      #12;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_sum", sum, 0);
      check("rst_cout", cout, 0);
      check("rst_fa", {fa_a, fa_b, fa_cin}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ena   = 1'b1;
      @(negedge clk);

      // Basic sum 0x03 + 0x05
      check("idle_busy", busy, 0);
      launch(8'h03, 8'h05, 1'b0);
      wait_done(0, 0, 0, cyc, stalls, bcyc);
      check("basic_latency", cyc, W);
      check("basic_busy_cycles", bcyc, W);
      check("basic_sum", sum, 8'h08);
      check("basic_cout", cout, 0);
      @(negedge clk);
      check("basic_done_pulse", done, 0);
      check("basic_sum_hold_idle", sum, 8'h08);

      // Carry ripple
      launch(8'hFF, 8'h01, 1'b0);
      wait_done(0, 0, 0, cyc, stalls, bcyc);
      check("ripple1_sum", sum, 8'h00);
      check("ripple1_cout", cout, 1);
      @(negedge clk);
      launch(8'hFF, 8'hFF, 1'b1);
      wait_done(0, 0, 0, cyc, stalls, bcyc);
      check("ripple2_sum", sum, 8'hFF);
      check("ripple2_cout", cout, 1);
      @(negedge clk);

      // Busy lockout: start held, operands change during RUN
      op_a  = 8'h10;
      op_b  = 8'h20;
      cin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      op_a = 8'hAA;
      op_b = 8'h55;
      wait_done(0, 0, 0, cyc, stalls, bcyc);
      check("lock_latency", cyc, W);
      check("lock_sum1", sum, 8'h30);
      check("lock_cout1", cout, 0);
      c = 0;
      do begin
         @(negedge clk);
         c++;
         if (c == 4) begin
            check("lock_busy_mid", busy, 1);
            check("lock_sum_hold_run", sum, 8'h30);
         end
      end while (done !== 1'b1 && c < 50);
      start = 1'b0;
      check("lock_spacing", c, W + 1);
      check("lock_sum2", sum, 8'hFF);
      check("lock_cout2", cout, 0);
      @(negedge clk);
      check("lock_done_pulse", done, 0);

      // ena stall: 3 frozen edges mid-run
      launch(8'h03, 8'h05, 1'b0);
      wait_done(2, 3, 3, cyc, stalls, bcyc);
      check("stall_latency", cyc, W + 3);
      check("stall_sum", sum, 8'h08);
      @(negedge clk);

      // Reset mid-run
      launch(8'h7F, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      check("prerst_fa_a", fa_a, 1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_sum", sum, 0);
      check("midrst_cout", cout, 0);
      check("midrst_fa", {fa_a, fa_b, fa_cin}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_busy", busy, 0);
      launch(8'h7F, 8'h01, 1'b0);
      wait_done(0, 0, 0, cyc, stalls, bcyc);
      check("postrst_latency", cyc, W);
      check("postrst_sum", sum, 8'h80);
      check("postrst_cout", cout, 0);
      @(negedge clk);

      // Random sweep
      for (int i = 0; i < 500; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         a     = W'($urandom());
         b     = W'($urandom());
         ci    = 1'($urandom_range(1));
         exp_r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
         launch(a, b, ci);
         op_a = W'($urandom());
         op_b = W'($urandom());
         wait_done(1, 0, 0, cyc, stalls, bcyc);
         check("rnd_latency", cyc, W + stalls);
         check("rnd_sum", sum, exp_r[W-1:0]);
         check("rnd_cout", cout, exp_r[W]);
         @(negedge clk);
         check("rnd_done_pulse", done, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
